// File: rtl/run_controller.sv
// Run sequencer for the pipelined core: holds core reset, counts run cycles,
// and ends the run on a PC self-loop, a programmed halt PC, or a cycle budget.
module run_controller #(
  parameter int                PC_WIDTH     = 32,
  parameter int                CNT_WIDTH    = 32,
  parameter int                RESET_CYCLES = 4,
  parameter int                MAX_CYCLES   = 1000,
  parameter int                STALL_LIMIT  = 8,
  parameter bit                HALT_EN      = 1'b0,
  parameter logic [PC_WIDTH-1:0] HALT_PC    = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PC_WIDTH-1:0]  pc_in,
  output logic                 core_reset,
  output logic                 running,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [PC_WIDTH-1:0]  halt_pc
);

  localparam int HOLD_W  = $clog2(RESET_CYCLES + 1);
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);
  localparam logic [HOLD_W-1:0]    HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [STALL_W-1:0]   STALL_LAST = STALL_W'(STALL_LIMIT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RESET_HOLD,
    RUN,
    HALTED,
    TIMEOUT
  } state_t;

  state_t               state_q, state_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [PC_WIDTH-1:0]  prev_pc_q, prev_pc_d;
  logic                 valid_q, valid_d;
  logic                 core_reset_q, core_reset_d;
  logic                 running_q, running_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
  logic [PC_WIDTH-1:0]  halt_pc_q, halt_pc_d;

  logic match;
  logic halt_hit;

  // valid_q keeps the stale prev_pc from matching on the first RUN sample
  assign match    = valid_q && (pc_in == prev_pc_q);
  assign halt_hit = (match && (stall_cnt_q == STALL_LAST)) ||
                    (HALT_EN && (pc_in == HALT_PC));

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    prev_pc_d     = prev_pc_q;
    valid_d       = valid_q;
    core_reset_d  = core_reset_q;
    running_d     = running_q;
    done_d        = done_q;
    timeout_d     = timeout_q;
    cycle_count_d = cycle_count_q;
    halt_pc_d     = halt_pc_q;

    case (state_q)
      IDLE: begin
        core_reset_d = 1'b1;
        if (start) begin
          state_d    = RESET_HOLD;
          hold_cnt_d = '0;
        end
      end

      RESET_HOLD: begin
        core_reset_d = 1'b1;
        hold_cnt_d   = hold_cnt_q + HOLD_W'(1);
        if (hold_cnt_q == HOLD_LAST) begin
          state_d       = RUN;
          core_reset_d  = 1'b0;
          running_d     = 1'b1;
          cycle_count_d = '0;
          stall_cnt_d   = '0;
          prev_pc_d     = '0;
          valid_d       = 1'b0;
        end
      end

      RUN: begin
        cycle_count_d = cycle_count_q + CNT_WIDTH'(1);
        prev_pc_d     = pc_in;
        valid_d       = 1'b1;
        stall_cnt_d   = match ? stall_cnt_q + STALL_W'(1) : '0;
        // Halt takes priority when it coincides with the last budgeted cycle
        if (halt_hit) begin
          state_d   = HALTED;
          done_d    = 1'b1;
          running_d = 1'b0;
          halt_pc_d = pc_in;
        end else if (cycle_count_q == CNT_LAST) begin
          state_d   = TIMEOUT;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          running_d = 1'b0;
          halt_pc_d = pc_in;
        end
      end

      HALTED, TIMEOUT: begin
        if (start) begin
          state_d      = RESET_HOLD;
          core_reset_d = 1'b1;
          done_d       = 1'b0;
          timeout_d    = 1'b0;
          hold_cnt_d   = '0;
        end
      end

      default: begin
        state_d      = IDLE;
        core_reset_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      hold_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      prev_pc_q     <= '0;
      valid_q       <= 1'b0;
      core_reset_q  <= 1'b1;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_count_q <= '0;
      halt_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      prev_pc_q     <= prev_pc_d;
      valid_q       <= valid_d;
      core_reset_q  <= core_reset_d;
      running_q     <= running_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      cycle_count_q <= cycle_count_d;
      halt_pc_q     <= halt_pc_d;
    end
  end

  assign core_reset  = core_reset_q;
  assign running     = running_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;
  assign halt_pc     = halt_pc_q;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: dut0 halts on self-loop only, dut1 also
// halts at PC 0x40. Both share stimulus; inputs change and outputs are read at negedge.
module tb_run_controller;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] pc_in;

  logic [1:0]  core_reset_o;
  logic [1:0]  running_o;
  logic [1:0]  done_o;
  logic [1:0]  timeout_o;
  logic [31:0] cycle_count_o [2];
  logic [31:0] halt_pc_o [2];

  int total = 0;
  int bad   = 0;

  run_controller #(
    .PC_WIDTH(32), .CNT_WIDTH(32), .RESET_CYCLES(4), .MAX_CYCLES(20),
    .STALL_LIMIT(3), .HALT_EN(1'b0), .HALT_PC(32'h0)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in),
    .core_reset(core_reset_o[0]), .running(running_o[0]), .done(done_o[0]),
    .timeout(timeout_o[0]), .cycle_count(cycle_count_o[0]), .halt_pc(halt_pc_o[0])
  );

  run_controller #(
    .PC_WIDTH(32), .CNT_WIDTH(32), .RESET_CYCLES(4), .MAX_CYCLES(20),
    .STALL_LIMIT(3), .HALT_EN(1'b1), .HALT_PC(32'h40)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in),
    .core_reset(core_reset_o[1]), .running(running_o[1]), .done(done_o[1]),
    .timeout(timeout_o[1]), .cycle_count(cycle_count_o[1]), .halt_pc(halt_pc_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag, input int d, input logic cr, input logic run,
                            input logic dn, input logic to, input logic [31:0] cc,
                            input logic [31:0] hp);
    checkOutput($sformatf("%s.d%0d.core_reset", tag, d), {31'b0, core_reset_o[d]}, {31'b0, cr});
    checkOutput($sformatf("%s.d%0d.running", tag, d), {31'b0, running_o[d]}, {31'b0, run});
    checkOutput($sformatf("%s.d%0d.done", tag, d), {31'b0, done_o[d]}, {31'b0, dn});
    checkOutput($sformatf("%s.d%0d.timeout", tag, d), {31'b0, timeout_o[d]}, {31'b0, to});
    checkOutput($sformatf("%s.d%0d.cycle_count", tag, d), cycle_count_o[d], cc);
    checkOutput($sformatf("%s.d%0d.halt_pc", tag, d), halt_pc_o[d], hp);
  endtask

  // Drive inputs for one cycle; returns at the following negedge
  task automatic applyStimulus(input logic s, input logic [31:0] pc);
    start = s;
    pc_in = pc;
    @(negedge clk);
  endtask

  // Start pulse, four reset-hold cycles, then first RUN cycle
  task automatic launch(input string tag);
    applyStimulus(1'b1, 32'h0);
    checkOutput({tag, ".hold.done"}, {31'b0, done_o[0]}, 32'd0);
    checkOutput({tag, ".hold.timeout"}, {31'b0, timeout_o[0]}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("%s.hold%0d.core_reset", tag, i), {31'b0, core_reset_o[0]}, 32'd1);
      checkOutput($sformatf("%s.hold%0d.running", tag, i), {31'b0, running_o[0]}, 32'd0);
      applyStimulus(1'b0, 32'h0);
    end
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s.run.d%0d.core_reset", tag, d), {31'b0, core_reset_o[d]}, 32'd0);
      checkOutput($sformatf("%s.run.d%0d.running", tag, d), {31'b0, running_o[d]}, 32'd1);
      checkOutput($sformatf("%s.run.d%0d.done", tag, d), {31'b0, done_o[d]}, 32'd0);
      checkOutput($sformatf("%s.run.d%0d.cycle_count", tag, d), cycle_count_o[d], 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pc_in = 32'h0;
    repeat (2) @(negedge clk);
    checkState("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkState("reset", 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // start while reset is high must be ignored
    applyStimulus(1'b1, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0);
    checkOutput("rst_beats_start.running", {31'b0, running_o[0]}, 32'd0);
    checkOutput("rst_beats_start.core_reset", {31'b0, core_reset_o[0]}, 32'd1);

    // Self-loop halt: 0,4,8,C,C,C,C halts on the 4th C
    launch("t1");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, (i < 3) ? 32'(i * 4) : 32'hC);
      if (i == 5) begin
        checkOutput("t2.pre.d0.done", {31'b0, done_o[0]}, 32'd0);
        checkOutput("t2.pre.d0.cycle_count", cycle_count_o[0], 32'd6);
      end
    end
    checkState("t2.halt", 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd7, 32'hC);
    checkState("t2.halt", 1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd7, 32'hC);
    applyStimulus(1'b0, 32'h99);
    applyStimulus(1'b0, 32'h40);
    checkState("t2.frozen", 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd7, 32'hC);
    checkState("t2.frozen", 1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd7, 32'hC);

    // Restart from HALTED; incrementing PC: dut1 halts at 0x40, dut0 times out
    launch("t6");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 32'(i * 4));
      if (i == 15) checkOutput("t4.pre.d1.done", {31'b0, done_o[1]}, 32'd0);
      if (i == 16) checkState("t4.halt_pc", 1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd17, 32'h40);
      if (i == 18) begin
        checkOutput("t3.pre.d0.done", {31'b0, done_o[0]}, 32'd0);
        checkOutput("t3.pre.d0.cycle_count", cycle_count_o[0], 32'd19);
        checkOutput("t3.pre.d0.running", {31'b0, running_o[0]}, 32'd1);
      end
    end
    checkState("t3.timeout", 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd20, 32'h4C);
    checkOutput("t4.frozen.d1.cycle_count", cycle_count_o[1], 32'd17);

    // Self-loop halt on the final budgeted cycle: halt wins over timeout
    launch("tA");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, (i < 16) ? 32'h100 + 32'(i * 4) : 32'h200);
      if (i == 18) checkOutput("tA.pre.d0.done", {31'b0, done_o[0]}, 32'd0);
    end
    checkState("tA.coincide", 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd20, 32'h200);
    checkState("tA.coincide", 1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd20, 32'h200);

    // Halt-PC hit on the final budgeted cycle
    launch("tB");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, (i < 19) ? 32'h300 + 32'(i * 4) : 32'h40);
    end
    checkState("tB.coincide", 1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd20, 32'h40);
    checkState("tB.timeout", 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd20, 32'h40);

    // start ignored in RESET_HOLD and RUN, then reset mid-run
    applyStimulus(1'b1, 32'h0);
    applyStimulus(1'b0, 32'h0);
    applyStimulus(1'b1, 32'h0);
    applyStimulus(1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0);
    checkOutput("t5.hold_start.running", {31'b0, running_o[0]}, 32'd1);
    checkOutput("t5.hold_start.cycle_count", cycle_count_o[0], 32'd0);
    for (int i = 0; i < 10; i++) applyStimulus(i == 4, 32'h500 + 32'(i * 4));
    checkOutput("t5.run_start.running", {31'b0, running_o[0]}, 32'd1);
    checkOutput("t5.run_start.cycle_count", cycle_count_o[0], 32'd10);
    checkOutput("t5.run_start.d1.cycle_count", cycle_count_o[1], 32'd10);
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0);
    reset = 1'b0;
    checkState("t5.reset", 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkState("t5.reset", 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
